// File: rtl/add_arb.sv
// Two-requester round-robin front end sharing one 32-bit carry-lookahead adder.
// The result register has latency 1 and sustains one result per cycle under drain.
module add_arb #(
  parameter int unsigned FIRST_PRI = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req0_cin,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  input  logic        req1_cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_s,
  output logic        out_cout,
  output logic        out_ovf,
  output logic        out_id
);

  // Carries into positions 1..3 of a 4-wide lookahead group.
  function automatic logic [2:0] carry3(input logic [2:0] g, input logic [2:0] p,
                                        input logic c);
    logic c1, c2, c3;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    return {c3, c2, c1};
  endfunction

  function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  logic        pri_q;
  logic        grant;
  logic        slot_free;
  logic        accept;
  logic [31:0] ax, ay;
  logic        acin;
  logic [31:0] gb, pb, sum;
  logic [7:0]  sg, sp, sc;
  logic        bg0, bp0, bg1, bp1, c16, c32;
  logic        ovf;

  always_comb begin
    if (req0_valid && req1_valid) grant = pri_q;
    else if (req1_valid)          grant = 1'b1;
    else                          grant = 1'b0;
  end

  assign slot_free  = !out_valid || out_ready;
  assign req0_ready = !rst && slot_free && req0_valid && (grant == 1'b0);
  assign req1_ready = !rst && slot_free && req1_valid && (grant == 1'b1);
  assign accept     = req0_ready || req1_ready;

  assign ax   = grant ? req1_x   : req0_x;
  assign ay   = grant ? req1_y   : req0_y;
  assign acin = grant ? req1_cin : req0_cin;

  // Bit g/p -> 8 slice g/p -> two 4-group generators -> top-level carries.
  always_comb begin
    gb = ax & ay;
    pb = ax ^ ay;
    sg = '0;
    sp = '0;
    for (int k = 0; k < 8; k++) begin
      sg[k] = grp_g(gb[4*k +: 4], pb[4*k +: 4]);
      sp[k] = &pb[4*k +: 4];
    end
    bg0 = grp_g(sg[3:0], sp[3:0]);
    bp0 = &sp[3:0];
    bg1 = grp_g(sg[7:4], sp[7:4]);
    bp1 = &sp[7:4];
    c16 = bg0 | (bp0 & acin);
    c32 = bg1 | (bp1 & bg0) | (bp1 & bp0 & acin);
    sc      = '0;
    sc[0]   = acin;
    sc[3:1] = carry3(sg[2:0], sp[2:0], acin);
    sc[4]   = c16;
    sc[7:5] = carry3(sg[6:4], sp[6:4], c16);
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      sum[4*k +: 4] = pb[4*k +: 4] ^ {carry3(gb[4*k +: 3], pb[4*k +: 3], sc[k]), sc[k]};
    end
  end

  assign ovf = (ax[31] == ay[31]) && (sum[31] != ax[31]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q     <= 1'(FIRST_PRI);
      out_valid <= 1'b0;
      out_s     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_id    <= 1'b0;
    end else if (accept) begin
      pri_q     <= ~grant;
      out_valid <= 1'b1;
      out_s     <= sum;
      out_cout  <= c32;
      out_ovf   <= ovf;
      out_id    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_arb.sv
// Directed bench for add_arb: reset, single requests, overflow, carry ripple,
// contention, backpressure and asynchronous reset mid-stream.
module tb_add_arb;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req0_cin;
  logic [31:0] req0_x, req0_y;
  logic        req1_valid, req1_ready, req1_cin;
  logic [31:0] req1_x, req1_y;
  logic        out_valid, out_ready, out_cout, out_ovf, out_id;
  logic [31:0] out_s;

  int n_chk  = 0;
  int n_fail = 0;

  add_arb #(.FIRST_PRI(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_cin   (req1_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_cout   (out_cout),
    .out_ovf    (out_ovf),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] s,
                         input logic co, input logic ov, input logic id);
    chk({tag, "_valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, "_s"},     out_s,              s);
    chk({tag, "_cout"},  {31'b0, out_cout},  {31'b0, co});
    chk({tag, "_ovf"},   {31'b0, out_ovf},   {31'b0, ov});
    chk({tag, "_id"},    {31'b0, out_id},    {31'b0, id});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, "_rdy0"}, {31'b0, req0_ready}, {31'b0, r0});
    chk({tag, "_rdy1"}, {31'b0, req1_ready}, {31'b0, r1});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_x     = 32'h0000_0001;
    req0_y     = 32'hFFFF_FFFF;
    req0_cin   = 1'b0;
    req1_valid = 1'b0;
    req1_x     = '0;
    req1_y     = '0;
    req1_cin   = 1'b0;
    #3;
    chk_out("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk_rdy("reset", 1'b0, 1'b0);

    // Release reset mid-cycle; the first edge afterwards accepts req0.
    tick();
    rst = 1'b0;
    #1;
    chk_rdy("single", 1'b1, 1'b0);
    tick();
    chk_out("single", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    req0_x = 32'h7FFF_FFFF;
    req0_y = 32'h0000_0001;
    #1;
    chk_rdy("ovf", 1'b1, 1'b0);
    tick();
    chk_out("ovf", 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

    req0_x   = 32'hFFFF_FFFF;
    req0_y   = 32'h0000_0000;
    req0_cin = 1'b1;
    tick();
    chk_out("cin", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

    // Result held, pri now 1; reset asynchronously mid-cycle.
    req0_valid = 1'b0;
    out_ready  = 1'b0;
    tick();
    chk_out("hold_pre_rst", 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    req0_valid = 1'b1;
    req0_x     = 32'h0000_0010;
    req0_y     = 32'h0000_0020;
    req0_cin   = 1'b0;
    req1_valid = 1'b1;
    req1_x     = 32'h0000_0100;
    req1_y     = 32'h0000_0200;
    req1_cin   = 1'b1;
    out_ready  = 1'b1;
    #1;
    chk_rdy("in_rst", 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_rdy("contend0", 1'b1, 1'b0);

    // Contention alternates 0,1,0,1 starting from FIRST_PRI.
    tick();
    chk_out("contend_a", 1'b1, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    chk_rdy("contend_a", 1'b0, 1'b1);
    tick();
    chk_out("contend_b", 1'b1, 32'h0000_0301, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("contend_c", 1'b1, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("contend_d", 1'b1, 32'h0000_0301, 1'b0, 1'b0, 1'b1);

    // Backpressure: req1 blocked while the result is held.
    req0_valid = 1'b0;
    req1_x     = 32'h0000_0005;
    req1_y     = 32'h0000_0006;
    req1_cin   = 1'b0;
    out_ready  = 1'b0;
    #1;
    chk_rdy("bp", 1'b0, 1'b0);
    tick();
    chk_out("bp_hold", 1'b1, 32'h0000_0301, 1'b0, 1'b0, 1'b1);
    chk_rdy("bp_hold", 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk_rdy("bp_release", 1'b0, 1'b1);
    tick();
    chk_out("drain_accept", 1'b1, 32'h0000_000B, 1'b0, 1'b0, 1'b1);

    req1_valid = 1'b0;
    tick();
    chk("drain_empty_valid", {31'b0, out_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/add_arb.md
ADD_ARB -- requirements
Module: add_arb

Interface
REQ-001 SHALL have parameter FIRST_PRI, default 0, meaning the requester holding priority after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has an operand pair.
REQ-005 SHALL have port req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-006 SHALL have port req0_x, req0_y  input  32 each  requester 0 operands.
REQ-007 SHALL have port req0_cin  input  1  requester 0 carry-in.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_x, req1_y, req1_cin, with the same directions, widths and meanings for requester 1.
REQ-009 SHALL have port out_valid  output  1  result register holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port out_s  output  32  registered sum.
REQ-012 SHALL have port out_cout  output  1  registered carry out of bit 31.
REQ-013 SHALL have port out_ovf  output  1  registered signed overflow.
REQ-014 SHALL have port out_id  output  1  requester that issued the result.

Function
REQ-015 SHALL contain exactly one 32-bit carry-lookahead adder, built from 4-bit CLA slices and 4-group lookahead generators, shared by both requesters.
REQ-016 SHALL define slot_free = !out_valid || out_ready, evaluated combinationally.
REQ-017 SHALL hold a 1-bit priority pointer pri; grant goes to reqN if only reqN_valid is high; if both are high, grant goes to requester pri.
REQ-018 SHALL drive reqN_ready = (grant == N) && reqN_valid && slot_free; reqN_ready SHALL be high for at most one requester per cycle.
REQ-019 SHALL, on an accept (some reqN_ready high), feed reqN_x, reqN_y, reqN_cin to the adder and register s, cout, ovf and id=N at that rising edge, so out_valid rises one cycle after the accept (latency 1).
REQ-020 SHALL compute out_ovf = (x[31] == y[31]) && (s[31] != x[31]).
REQ-021 SHALL set pri to the other requester after every accept and leave pri unchanged in cycles with no accept, so neither requester waits more than one grant while the other is also valid.
REQ-022 SHALL clear out_valid on out_ready && out_valid when there is no accept in the same cycle; a simultaneous drain and accept SHALL load the new result with out_valid staying high (full throughput, one result per cycle).
REQ-023 SHALL hold out_s, out_cout, out_ovf and out_id stable while out_valid && !out_ready.
REQ-024 SHALL not make reqN_ready depend on the other requester's ready; requesters SHALL hold valid and data stable until ready, and the block's response is undefined otherwise.
REQ-025 SHALL produce a 33-bit result with wrap-around modulo 2^32 in out_s; {out_cout, out_s} SHALL equal x + y + cin exactly.

Reset
REQ-026 SHALL, on rst high, immediately set out_valid=0, out_s=0, out_cout=0, out_ovf=0, out_id=0 and pri=FIRST_PRI, independent of clk.
REQ-027 SHALL hold req0_ready=req1_ready=0 while rst is high; a result pending when rst asserts SHALL be discarded, and no accept SHALL occur in that cycle.
REQ-028 SHALL resume arbitration on the first rising clk edge after rst deasserts.

Verification
REQ-029 SHALL cover single request: req0 x=0x0000_0001, y=0xFFFF_FFFF, cin=0 with out_ready=1 -> next cycle out_valid=1, out_s=0, out_cout=1, out_ovf=0, out_id=0.
REQ-030 SHALL cover signed overflow: x=0x7FFF_FFFF, y=0x0000_0001, cin=0 -> out_s=0x8000_0000, out_cout=0, out_ovf=1.
REQ-031 SHALL cover contention: both valid for 4 cycles, FIRST_PRI=0, out_ready=1 -> out_id sequence 0,1,0,1 with one result per cycle.
REQ-032 SHALL cover backpressure: out_ready=0 with a result held and req1 valid -> req1_ready=0 and outputs unchanged; out_ready=1 -> drain and accept in the same cycle, with out_valid staying high.
REQ-033 SHALL cover carry-in ripple: x=0xFFFF_FFFF, y=0, cin=1 -> out_s=0, out_cout=1.
REQ-034 SHALL cover reset mid-stream: rst pulsed while out_valid=1 and pri=1 -> out_valid=0 immediately, pri=FIRST_PRI, readies low during reset.
